threewire_slave_ctrl: RTL and testbench



---
 rtl/threewire_slave_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_threewire_slave_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/threewire_slave_ctrl.sv
// threewire_slave_ctrl: 3-wire (clock / chip-select / bidirectional data) slave endpoint.
// Oversamples the bus on in_clk and decodes frames of the form
// R/W bit, address (MSB first), then one or more data words (MSB first).
// Write words go out on the register write port. Read words are fetched from
// that port and shifted out on io_tw_data.
//
// Optional feature: define TWS_ADDR_AUTOINC_EN to advance out_reg_addr by one
// after each burst word. When it is undefined, every word of a frame uses the
// same address, which gives a FIFO-style port.
//
// Ports:
//   in_clk, in_rst_n         system clock, asynchronous active-low reset
//   in_tw_clock, in_tw_cs    bus clock and chip select (active low), asynchronous
//   io_tw_data               bidirectional data, driven only while out_tw_oe=1
//   out_tw_oe                board buffer direction (1 = slave drives)
//   out_reg_addr/wdata       register port address / write data
//   out_reg_wr, out_reg_rd   1-cycle strobes; in_reg_rdata is valid the cycle after rd
//   out_busy                 frame in progress
//   out_frame_err            1-cycle pulse when CS is deasserted mid-word
module threewire_slave_ctrl #(
    parameter int unsigned TWS_ADDRESS_BITS = 10,
    parameter int unsigned TWS_DATA_BITS    = 32,
    parameter int unsigned TWS_SYNC_STAGES  = 2
) (
    input  logic                        in_clk,
    input  logic                        in_rst_n,
    input  logic                        in_tw_clock,
    input  logic                        in_tw_cs,
    inout  wire                         io_tw_data,
    output logic                        out_tw_oe,
    output logic [TWS_ADDRESS_BITS-1:0] out_reg_addr,
    output logic [TWS_DATA_BITS-1:0]    out_reg_wdata,
    output logic                        out_reg_wr,
    output logic                        out_reg_rd,
    input  logic [TWS_DATA_BITS-1:0]    in_reg_rdata,
    output logic                        out_busy,
    output logic                        out_frame_err
);

    localparam int unsigned AW   = TWS_ADDRESS_BITS;
    localparam int unsigned DW   = TWS_DATA_BITS;
    localparam int unsigned SW   = TWS_SYNC_STAGES;
    localparam int unsigned AS   = AW - 1;
    localparam int unsigned MAXW = (AW > DW) ? AW : DW;
    localparam int unsigned CW   = $clog2(MAXW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RW,
        S_ADDR,
        S_RD_TURN,
        S_RD_DATA,
        S_WR_DATA
    } state_t;

    state_t          state;
    logic [SW-1:0]   clk_sync;
    logic [SW-1:0]   cs_sync;
    logic [SW-1:0]   dat_sync;
    logic            clk_prev;
    logic            tw_rise;
    logic            cs_high;
    logic            dat_s;
    logic            mid_word;
    logic [CW-1:0]   bit_cnt;
    logic [AS-1:0]   addr_sh;
    logic [DW-1:0]   data_sh;
    logic            tx_bit;
    logic            is_write;
    logic            wr_pend;
    logic            rd_reload;

    // Only the slave's tristate driver; the master side lives on the board.
    assign io_tw_data = out_tw_oe ? tx_bit : 1'bz;

    assign tw_rise = clk_sync[SW-1] & ~clk_prev;
    assign cs_high = cs_sync[SW-1];
    assign dat_s   = dat_sync[SW-1];

    // Input synchronizers; CS resets high so a reset never looks like a frame start.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            clk_sync <= '0;
            cs_sync  <= '1;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SW-2:0], in_tw_clock};
            cs_sync  <= {cs_sync[SW-2:0], in_tw_cs};
            dat_sync <= {dat_sync[SW-2:0], io_tw_data};
            clk_prev <= clk_sync[SW-1];
        end
    end

    // A frame ending with CS high is clean only on a word boundary.
    always_comb begin
        mid_word = 1'b0;
        case (state)
            S_RW, S_ADDR: mid_word = 1'b1;
            S_WR_DATA:    mid_word = (bit_cnt != CW'(DW - 1));
            S_RD_DATA:    mid_word = !rd_reload;
            default:      mid_word = 1'b0;
        endcase
    end

    // Frame decoder with registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state         <= S_IDLE;
            out_tw_oe     <= 1'b0;
            out_reg_addr  <= '0;
            out_reg_wdata <= '0;
            out_reg_wr    <= 1'b0;
            out_reg_rd    <= 1'b0;
            out_busy      <= 1'b0;
            out_frame_err <= 1'b0;
            bit_cnt       <= '0;
            addr_sh       <= '0;
            data_sh       <= '0;
            tx_bit        <= 1'b0;
            is_write      <= 1'b0;
            wr_pend       <= 1'b0;
            rd_reload     <= 1'b0;
        end else begin
            out_reg_wr    <= 1'b0;
            out_reg_rd    <= 1'b0;
            out_frame_err <= 1'b0;

            // A completed write word strobes one cycle after wdata settles,
            // even if CS has already gone high.
            if (wr_pend) begin
                out_reg_wr <= 1'b1;
                wr_pend    <= 1'b0;
            end
`ifdef TWS_ADDR_AUTOINC_EN
            if (out_reg_wr) begin
                out_reg_addr <= out_reg_addr + AW'(1);
            end
`endif

            if ((state != S_IDLE) && cs_high) begin
                state     <= S_IDLE;
                out_tw_oe <= 1'b0;
                out_busy  <= 1'b0;
                rd_reload <= 1'b0;
                if (mid_word) begin
                    out_frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!cs_high) begin
                            state    <= S_RW;
                            out_busy <= 1'b1;
                        end
                    end
                    S_RW: begin
                        if (tw_rise) begin
                            is_write <= dat_s;
                            bit_cnt  <= CW'(AW - 1);
                            state    <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (tw_rise) begin
                            addr_sh <= AS'({addr_sh, dat_s});
                            if (bit_cnt == '0) begin
                                out_reg_addr <= {addr_sh, dat_s};
                                if (is_write) begin
                                    bit_cnt <= CW'(DW - 1);
                                    state   <= S_WR_DATA;
                                end else begin
                                    out_reg_rd <= 1'b1;
                                    state      <= S_RD_TURN;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - CW'(1);
                            end
                        end
                    end
                    S_RD_TURN: begin
                        if (tw_rise) begin
                            tx_bit    <= in_reg_rdata[DW-1];
                            data_sh   <= {in_reg_rdata[DW-2:0], 1'b0};
                            out_tw_oe <= 1'b1;
                            bit_cnt   <= CW'(DW - 2);
                            rd_reload <= 1'b0;
                            state     <= S_RD_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (tw_rise) begin
                            if (rd_reload) begin
                                // Next burst word: its rdata was prefetched after bit 0.
                                tx_bit    <= in_reg_rdata[DW-1];
                                data_sh   <= {in_reg_rdata[DW-2:0], 1'b0};
                                bit_cnt   <= CW'(DW - 2);
                                rd_reload <= 1'b0;
                            end else begin
                                tx_bit  <= data_sh[DW-1];
                                data_sh <= {data_sh[DW-2:0], 1'b0};
                                if (bit_cnt == '0) begin
                                    rd_reload  <= 1'b1;
                                    out_reg_rd <= 1'b1;
`ifdef TWS_ADDR_AUTOINC_EN
                                    out_reg_addr <= out_reg_addr + AW'(1);
`endif
                                end else begin
                                    bit_cnt <= bit_cnt - CW'(1);
                                end
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (tw_rise) begin
                            data_sh <= {data_sh[DW-2:0], dat_s};
                            if (bit_cnt == '0) begin
                                out_reg_wdata <= {data_sh[DW-2:0], dat_s};
                                wr_pend       <= 1'b1;
                                bit_cnt       <= CW'(DW - 1);
                            end else begin
                                bit_cnt <= bit_cnt - CW'(1);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_threewire_slave_ctrl.sv
// Testbench for threewire_slave_ctrl: a bus master driven from a table of
// frames, a synchronous register-file model, and write/strobe monitors.
module tb_threewire_slave_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned H  = 6;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          tw_clock = 1'b0;
    logic          tw_cs    = 1'b1;
    logic          m_oe     = 1'b0;
    logic          m_data   = 1'b0;
    wire           tw_data;
    logic          tw_oe;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_wr;
    logic          reg_rd;
    logic [DW-1:0] reg_rdata = '0;
    logic          busy;
    logic          frame_err;

    assign tw_data = m_oe ? m_data : 1'bz;

    threewire_slave_ctrl #(
        .TWS_ADDRESS_BITS(AW),
        .TWS_DATA_BITS   (DW),
        .TWS_SYNC_STAGES (2)
    ) dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_tw_clock  (tw_clock),
        .in_tw_cs     (tw_cs),
        .io_tw_data   (tw_data),
        .out_tw_oe    (tw_oe),
        .out_reg_addr (reg_addr),
        .out_reg_wdata(reg_wdata),
        .out_reg_wr   (reg_wr),
        .out_reg_rd   (reg_rd),
        .in_reg_rdata (reg_rdata),
        .out_busy     (busy),
        .out_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Register file model: 0x0A0 holds 0x12345678, every other address n holds n*0x11111111.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 10'h0A0) return 32'h1234_5678;
        return 32'(32'(a) * 32'h1111_1111);
    endfunction

    always_ff @(posedge clk) begin
        if (reg_rd) reg_rdata <= mem_val(reg_addr);
    end

    // Monitors sampled on the falling edge of clk.
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int unsigned   rd_n  = 0;
    int unsigned   err_n = 0;
    int unsigned   ovl_n = 0;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_rd) rd_n++;
        if (frame_err) err_n++;
        if (reg_wr && reg_rd) ovl_n++;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master drives data after a falling edge; the slave samples it on the rise.
    task automatic send_bit(input logic b);
        m_oe   = 1'b1;
        m_data = b;
        wait_cyc(H);
        tw_clock = 1'b1;
        wait_cyc(H);
        tw_clock = 1'b0;
    endtask

    typedef struct packed {
        logic                is_wr;
        logic [AW-1:0]       addr;
        logic [2:0]          nwords;
        logic [3:0][DW-1:0]  data;      // write payload, or expected read words
        logic [5:0]          abort_bits; // 0 = complete frame
        logic [2:0]          exp_nwr;
        logic [2:0]          exp_nrd;
        logic [3:0][AW-1:0]  exp_addr;
        logic                exp_err;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int unsigned   err0;
        int unsigned   rd0;
        int unsigned   sent;
        bit            stop;
        logic [DW-1:0] word;
        wr_addr_q.delete();
        wr_data_q.delete();
        err0 = err_n;
        rd0  = rd_n;
        sent = 0;
        stop = 1'b0;
        tw_cs = 1'b0;
        wait_cyc(H);
        send_bit(v.is_wr);
        for (int i = int'(AW) - 1; i >= 0; i--) send_bit(v.addr[i]);
        if (v.is_wr) begin
            for (int w = 0; w < int'(v.nwords) && !stop; w++) begin
                for (int b = int'(DW) - 1; b >= 0 && !stop; b--) begin
                    send_bit(v.data[w][b]);
                    sent++;
                    if (v.abort_bits != 0 && sent == 32'(v.abort_bits)) stop = 1'b1;
                end
            end
        end else begin
            m_oe = 1'b0;
            for (int w = 0; w < int'(v.nwords) && !stop; w++) begin
                word = '0;
                for (int b = int'(DW) - 1; b >= 0 && !stop; b--) begin
                    wait_cyc(H);
                    tw_clock = 1'b1;
                    wait_cyc(H);
                    word[b]  = tw_data;
                    tw_clock = 1'b0;
                    sent++;
                    if (v.abort_bits != 0 && sent == 32'(v.abort_bits)) stop = 1'b1;
                end
                if (!stop) check("rd_word", idx * 10 + w, word, v.data[w]);
            end
        end
        wait_cyc(H);
        tw_cs = 1'b1;
        m_oe  = 1'b0;
        wait_cyc(4 * H);
        check("wr_count", idx, 32'(wr_addr_q.size()), 32'(v.exp_nwr));
        for (int i = 0; i < int'(v.exp_nwr) && i < wr_addr_q.size(); i++) begin
            check("wr_addr", idx * 10 + i, 32'(wr_addr_q[i]), 32'(v.exp_addr[i]));
            check("wr_data", idx * 10 + i, wr_data_q[i], v.data[i]);
        end
        check("rd_count", idx, rd_n - rd0, 32'(v.exp_nrd));
        check("frame_err", idx, err_n - err0, 32'(v.exp_err));
        check("busy_end", idx, 32'(busy), 32'd0);
        check("oe_end", idx, 32'(tw_oe), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int unsigned err0;

        vecs[0] = '{is_wr: 1'b1, addr: 10'h155, nwords: 3'd1,
                    data: {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, abort_bits: 6'd0,
                    exp_nwr: 3'd1, exp_nrd: 3'd0,
                    exp_addr: {10'h0, 10'h0, 10'h0, 10'h155}, exp_err: 1'b0};
        vecs[1] = '{is_wr: 1'b0, addr: 10'h0A0, nwords: 3'd1,
                    data: {32'h0, 32'h0, 32'h0, 32'h1234_5678}, abort_bits: 6'd0,
                    exp_nwr: 3'd0, exp_nrd: 3'd2, exp_addr: '0, exp_err: 1'b0};
`ifdef TWS_ADDR_AUTOINC_EN
        vecs[2] = '{is_wr: 1'b1, addr: 10'h3FE, nwords: 3'd4,
                    data: {32'hF0F0_0004, 32'h0F0F_0003, 32'h5A5A_0002, 32'hA5A5_0001},
                    abort_bits: 6'd0, exp_nwr: 3'd4, exp_nrd: 3'd0,
                    exp_addr: {10'h001, 10'h000, 10'h3FF, 10'h3FE}, exp_err: 1'b0};
        vecs[3] = '{is_wr: 1'b0, addr: 10'h004, nwords: 3'd3,
                    data: {32'h0, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444},
                    abort_bits: 6'd0, exp_nwr: 3'd0, exp_nrd: 3'd4, exp_addr: '0, exp_err: 1'b0};
`else
        vecs[2] = '{is_wr: 1'b1, addr: 10'h3FE, nwords: 3'd4,
                    data: {32'hF0F0_0004, 32'h0F0F_0003, 32'h5A5A_0002, 32'hA5A5_0001},
                    abort_bits: 6'd0, exp_nwr: 3'd4, exp_nrd: 3'd0,
                    exp_addr: {10'h3FE, 10'h3FE, 10'h3FE, 10'h3FE}, exp_err: 1'b0};
        vecs[3] = '{is_wr: 1'b0, addr: 10'h004, nwords: 3'd3,
                    data: {32'h0, 32'h4444_4444, 32'h4444_4444, 32'h4444_4444},
                    abort_bits: 6'd0, exp_nwr: 3'd0, exp_nrd: 3'd4, exp_addr: '0, exp_err: 1'b0};
`endif
        vecs[4] = '{is_wr: 1'b1, addr: 10'h010, nwords: 3'd1,
                    data: {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D}, abort_bits: 6'd17,
                    exp_nwr: 3'd0, exp_nrd: 3'd0, exp_addr: '0, exp_err: 1'b1};
        vecs[5] = '{is_wr: 1'b0, addr: 10'h020, nwords: 3'd1,
                    data: {32'h0, 32'h0, 32'h0, 32'h2222_2220}, abort_bits: 6'd5,
                    exp_nwr: 3'd0, exp_nrd: 3'd1, exp_addr: '0, exp_err: 1'b1};

        // Reset values
        wait_cyc(4);
        check("rst_oe", 0, 32'(tw_oe), 32'd0);
        check("rst_wr", 0, 32'(reg_wr), 32'd0);
        check("rst_rd", 0, 32'(reg_rd), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd0);
        check("rst_err", 0, 32'(frame_err), 32'd0);
        check("rst_addr", 0, 32'(reg_addr), 32'd0);
        check("rst_wdata", 0, reg_wdata, 32'd0);
        rst_n = 1'b1;
        wait_cyc(4);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // CS released partway through the address field.
        wr_addr_q.delete();
        err0  = err_n;
        tw_cs = 1'b0;
        wait_cyc(H);
        check("busy_frame", 0, 32'(busy), 32'd1);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_cyc(H);
        tw_cs = 1'b1;
        m_oe  = 1'b0;
        wait_cyc(4 * H);
        check("addr_abort_err", 0, err_n - err0, 32'd1);
        check("addr_abort_wr", 0, 32'(wr_addr_q.size()), 32'd0);
        check("addr_abort_busy", 0, 32'(busy), 32'd0);

        // Reset during the read data phase releases the bus at once.
        tw_cs = 1'b0;
        wait_cyc(H);
        send_bit(1'b0);
        for (int i = int'(AW) - 1; i >= 0; i--) send_bit(vecs[1].addr[i]);
        m_oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_cyc(H);
            tw_clock = 1'b1;
            wait_cyc(H);
            tw_clock = 1'b0;
        end
        check("oe_reading", 0, 32'(tw_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("oe_in_reset", 0, 32'(tw_oe), 32'd0);
        check("busy_in_reset", 0, 32'(busy), 32'd0);
        check("addr_in_reset", 0, 32'(reg_addr), 32'd0);
        tw_cs    = 1'b1;
        tw_clock = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        run_vec(10, vecs[0]);

        check("wr_rd_overlap", 0, ovl_n, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
